// File: rtl/ram.sv
// rtl/ram.sv - single-port RAM with address register (MAR) and shared tri-state data bus
// Optional build macro RAM_PARITY_EN adds a stored even-parity bit per word and parity_err.
module ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic              sa,
    input  logic              s,
    input  logic              e,
`ifdef RAM_PARITY_EN
    output logic              parity_err,
`endif
    inout  wire  [DATA_W-1:0] bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_en;

    // A write always wins over a read, so the bus is never driven while it is being sampled.
    assign wr_en   = rst_n & s;
    assign rd_en   = rst_n & e & ~s;
    assign rd_data = mem[mar];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
        end else if (sa) begin
            mar <= a;
        end
    end

    // The array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[mar] <= bus;
        end
    end

    assign bus = rd_en ? rd_data : {DATA_W{1'bz}};

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[mar] <= ^bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (e && !s) begin
            parity_err <= par_mem[mar] ^ (^rd_data);
        end
    end
`endif

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - self-checking bench for ram: directed vector table, reset sequences, random mix vs array model.
module tb_ram;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] a      = 8'h00;
    logic       sa     = 1'b0;
    logic       s      = 1'b0;
    logic       e      = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_d  = 8'h00;
    wire  [7:0] bus;

    assign bus = drv_en ? drv_d : 8'hzz;

`ifdef RAM_PARITY_EN
    logic parity_err;
`endif

    ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .sa         (sa),
        .s          (s),
        .e          (e),
`ifdef RAM_PARITY_EN
        .parity_err (parity_err),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain array of words plus the current address register value.
    logic [7:0] model_mem [256];
    logic [7:0] model_mar;

    typedef struct {
        logic       sa;
        logic [7:0] a;
        logic       s;
        logic       e;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // The bench drives 0 whenever the RAM must be high-Z, so any RAM drive of a nonzero word shows up.
    task automatic apply(input string name, input logic sa_i, input logic [7:0] a_i,
                         input logic s_i, input logic e_i, input logic [7:0] d_i,
                         input logic use_exp, input logic [7:0] exp_i);
        logic [7:0] exp_v;
        @(negedge clk);
        sa = sa_i;
        a  = a_i;
        s  = s_i;
        e  = e_i;
        if (s_i) begin
            drv_en = 1'b1;
            drv_d  = d_i;
        end else if (e_i) begin
            drv_en = 1'b0;
        end else begin
            drv_en = 1'b1;
            drv_d  = 8'h00;
        end
        if (use_exp)  exp_v = exp_i;
        else if (s_i) exp_v = d_i;
        else if (e_i) exp_v = model_mem[model_mar];
        else          exp_v = 8'h00;
        #2;
        check(name, bus, exp_v);
        @(posedge clk);
        if (s_i)  model_mem[model_mar] = d_i;
        if (sa_i) model_mar = a_i;
        #1;
`ifdef RAM_PARITY_EN
        check({name, "_parity"}, {7'b0, parity_err}, 8'h00);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5};
        vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h5A};
        vecs[4]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hA5};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h5A};
        vecs[9]  = '{1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 8'h99};
        vecs[11] = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 8'h30, 1'b1, 1'b0, 8'h77, 8'h77};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h99};
        vecs[14] = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h77};
        vecs[16] = '{1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h3C};
        vecs[19] = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h00, 8'h3C};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hA5};
        vecs[21] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00};

        // Power-up reset: RAM must not drive even with e=1, and sa/s must be ignored.
        model_mar = 8'h00;
        e = 1'b1; drv_en = 1'b1; drv_d = 8'h00;
        #12;
        check("reset_bus_z", bus, 8'h00);
`ifdef RAM_PARITY_EN
        check("reset_parity_err", {7'b0, parity_err}, 8'h00);
`endif
        @(negedge clk);
        e = 1'b0;
        rst_n = 1'b1;

        // Fill every address with a nonzero word, then read every address back.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = (i == 0) ? 8'hC3 : 8'($urandom_range(1, 255));
            apply("fill_set", 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            apply("fill_wr", 1'b0, 8'h00, 1'b1, 1'b0, d, 1'b0, 8'h00);
        end
        for (int i = 0; i < 256; i++) begin
            apply("readback_set", 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            apply($sformatf("readback_%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        end

        for (int i = 0; i < 22; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].sa, vecs[i].a, vecs[i].s, vecs[i].e,
                  vecs[i].d, 1'b1, vecs[i].exp);
        end

        // Reset asserted mid-cycle with MAR at a written word; contents must survive.
        apply("pre_rst_set", 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        apply("pre_rst_wr", 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00);
        @(negedge clk);
        sa = 1'b0; s = 1'b0; e = 1'b1; drv_en = 1'b0;
        #1;
        check("pre_rst_read", bus, 8'hFF);
        rst_n = 1'b0;
        drv_en = 1'b1; drv_d = 8'h00;
        #1;
        check("rst_async_z", bus, 8'h00);
        model_mar = 8'h00;
        sa = 1'b1; a = 8'h40; s = 1'b1; drv_d = 8'h11;
        @(posedge clk);
        #1;
        check("rst_held_z", bus, 8'h11);
        @(negedge clk);
        sa = 1'b0; s = 1'b0; drv_en = 1'b0; e = 1'b1;
        rst_n = 1'b1;
        #2;
        check("rst_mar_zero", bus, 8'hC3);
        apply("post_rst_set", 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        apply("post_rst_read05", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF);
        apply("post_rst_set40", 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        apply("post_rst_read40", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

        // Random strobe mix against the array model.
        for (int i = 0; i < 400; i++) begin
            apply($sformatf("rand_%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(1, 255)), 1'b0, 8'h00);
        end
        for (int i = 0; i < 256; i += 17) begin
            apply("final_set", 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            apply($sformatf("final_read_%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
